// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding MIPS HI/LO; one step per cycle,
// fixed WIDTH+1 cycle latency for every operation, with MTHI/MTLO write ports.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_out_q, dz_out_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Shift-add: upper half accumulates the multiplicand, low half shifts out multiplier bits.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // Restoring divide: partial remainder in upper half, dividend/quotient in lower half.
    // The trial difference needs two guard bits since the shifted remainder can exceed 2^WIDTH.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0]   shifted;
        logic [WIDTH+1:0] trial;
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, d};
        if (!trial[WIDTH+1])
            return {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction

    assign sgn_op = op[0];
    assign a_mag  = magnitude(a, sgn_op);
    assign b_mag  = magnitude(b, sgn_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_out_d  = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    busy_d    = 1'b1;
                    cnt_d     = CW'(WIDTH);
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opb_d     = b_mag;
                    is_div_d  = op[1];
                    dz_d      = op[1] && (b == '0);
                    neg_res_d = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn_op && a[WIDTH-1];
                end
            end
            CALC: begin
                if (flush) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    acc_d = is_div_q ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                busy_d = 1'b0;
                if (!flush) begin
                    done_d   = 1'b1;
                    dz_out_d = dz_q;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                    end else begin
                        hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        lo_d = dz_q ? {WIDTH{1'b1}}
                                    : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    end
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_out_q <= dz_out_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Operand and accumulator state is always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        opb_q     <= opb_d;
        is_div_q  <= is_div_d;
        dz_q      <= dz_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation from an idle point (#1 after an edge) and waits for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; op = 0; a = 0; b = 0; flush = 0;
        hi_we = 0; lo_we = 0; wdata = 0;
        #1;
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, div_by_zero}); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        int lat, bcnt;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
        checks++; if (bcnt !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bcnt); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult();
        int lat, bcnt;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg: got %h expected ffffffffffffffeb", {hi, lo}); end
        @(posedge clk); #1;
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        checks++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mult_minmin: got %h expected 4000000000000000", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_divide();
        int lat, bcnt;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h expected fffffffffffffffd", {hi, lo}); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
        @(posedge clk); #1;
        run_op(2'b10, 32'd100, 32'd7, lat, bcnt);
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu: got %h expected 000000020000000e", {hi, lo}); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dz_flag: got %b expected 0", div_by_zero); end
        @(posedge clk); #1;
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo}); end
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFF_FFF0, 32'hFFFF_FFF1, lat, bcnt);
        checks++; if ({hi, lo} !== 64'hFFFF_FFF0_0000_0000) begin errors++; $display("FAIL divu_big: got %h expected fffffff000000000", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        int lat, bcnt;
        run_op(2'b10, 32'd5, 32'd0, lat, bcnt);
        checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency: got %0d expected 33", lat); end
        checks++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin errors++; $display("FAIL dz_result: got %h expected 00000005ffffffff", {hi, lo}); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
        @(posedge clk); #1;
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear: got %b expected 0", div_by_zero); end
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
        checks++; if ({hi, lo, div_by_zero} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL dz_signed: got %h/%h/%b expected fffffffb/ffffffff/1", hi, lo, div_by_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat;
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            if (lat == 5) begin op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        if (!done) lat = -1;
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
        checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin errors++; $display("FAIL ignore_result: got %h expected 0000000000000006", {hi, lo}); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got busy %b expected 0", busy); end
    endtask

    task automatic test_flush();
        int seen;
        op = 2'b00; a = 32'h0000_FFFF; b = 32'h0000_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
        checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin errors++; $display("FAIL flush_hilo: got %h expected 0000000000000006", {hi, lo}); end
    endtask

    task automatic test_mthi_mtlo();
        int lat, bcnt;
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_idle: got %h expected 00001234", hi); end
        lo_we = 1'b1; wdata = 32'h0000_0055;
        @(posedge clk); #1;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h0000_0055) begin errors++; $display("FAIL mtlo_idle: got %h expected 00000055", lo); end
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_busy: got %h expected 00001234", hi); end
        lat = 0;
        while (lat < 100 && !done) begin @(posedge clk); #1; lat++; end
        checks++; if ({done, hi, lo} !== {1'b1, 32'd0, 32'd42}) begin errors++; $display("FAIL mthi_busy_result: got %b/%h/%h expected 1/00000000/0000002a", done, hi, lo); end
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h0000_ABCD;
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0; start = 1'b0;
        checks++; if ({busy, hi} !== {1'b1, 32'h0000_ABCD}) begin errors++; $display("FAIL mthi_with_start: got %b/%h expected 1/0000abcd", busy, hi); end
        lat = 0;
        while (lat < 100 && !done) begin @(posedge clk); #1; lat++; end
        checks++; if ({hi, lo} !== {32'd0, 32'd9}) begin errors++; $display("FAIL mthi_overwritten: got %h expected 0000000000000009", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_op(2'b00, 32'd3, 32'd5, lat, bcnt);
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL b2b_first: got %h expected 0000000f", lo); end
        run_op(2'b10, 32'd100, 32'd7, lat, bcnt);
        checks++; if (bcnt !== 33) begin errors++; $display("FAIL b2b_accept: got busy cycles %0d expected 33", bcnt); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_second: got %h expected 000000020000000e", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat, bcnt;
        op = 2'b01; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 20; i++) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin errors++; $display("FAIL areset_outputs: got %b/%b/%b/%h/%h expected all 0", busy, done, div_by_zero, hi, lo); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL areset_discard: got %b expected 00", {busy, done}); end
        run_op(2'b00, 32'd6, 32'd7, lat, bcnt);
        checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL areset_after: got %h expected 000000000000002a", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_divide();
        test_div_by_zero();
        test_start_ignored();
        test_flush();
        test_mthi_mtlo();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative integer multiply/divide unit for the MIPS core, parametrised in operand width. It executes MULT, MULTU, DIV and DIVU as a multi-cycle operation and holds the results in architectural HI/LO registers, with MTHI/MTLO write ports. It sits beside the ALU in the execute stage. It drives `busy` so the pipeline control can stall any HI/LO-dependent instruction until `done`.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. Must be ≥ 4 and even.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled only when `busy`=0.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (rs); sampled with `start`.
- `b` in WIDTH: multiplier or divisor (rt); sampled with `start`.
- `flush` in 1: synchronous abort of an in-flight operation.
- `hi_we`, `lo_we` in 1: MTHI/MTLO write enables; honoured only when `busy`=0.
- `wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle pulse; HI/LO are updated and valid.
- `div_by_zero` out 1: qualifies `done` for a divide whose `b`=0.
- `hi` out WIDTH: HI register (product upper half, or remainder).
- `lo` out WIDTH: LO register (product lower half, or quotient).

## Operation
- **FSM states:** IDLE, CALC, FIX.
- **IDLE:** `start`=1 latches `op`, the magnitudes of `a` and `b` (signed ops only), the result signs, and the zero-divisor flag. The iteration counter loads `WIDTH`, and the FSM moves to CALC.
- **CALC:** one radix-2 step per cycle.
  - Multiply: shift-add into a 2×WIDTH accumulator.
  - Divide: restoring shift-subtract producing a quotient and partial remainder.
  - The counter decrements each step; when it reaches 0 the FSM moves to FIX.
- **FIX:**
  - Apply sign correction. Signed multiply negates the 2×WIDTH product if the sign of `a` differs from the sign of `b`. Signed quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- **MIPS result mapping:**
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: HI = remainder, LO = quotient.
- **Divide by zero:** no trap. The operation runs the full latency, then HI = `a` (unmodified), LO = all ones, and `div_by_zero`=1 alongside `done`.
- **Overflow:** DIV of most-negative ÷ −1 gives LO = most-negative, HI = 0. This is the natural wrap; no flag is raised.
- **MTHI/MTLO:** `hi_we`/`lo_we` with `busy`=0 write `wdata` at the edge. If an operation is accepted in the same cycle, the write still lands and is later overwritten at FIX.
- **`start` while busy:** ignored, with no queueing.
- **`flush`:** with `busy`=1, the FSM returns to IDLE at the next edge. HI/LO keep their prior values and no `done` is produced. `flush` has priority over `start` in the same cycle.

## Timing
- **Reset values (asynchronous on `rst_n`=0):** state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, counter 0. Reset mid-operation discards it.
- **Acceptance edge E0** (`start`=1, `busy`=0):
  - `busy`=1 from after E0 until after E(W+1), i.e. WIDTH+1 cycles.
  - The CALC steps occur at E1…EW; FIX occurs at E(W+1).
- **Latency:** after E(W+1), `hi`/`lo` hold the result, `done`=1 for exactly one cycle, and `busy`=0. The latency is WIDTH+1 cycles for every op, including divide by zero.
- **`done` cycle:** equivalent to IDLE, so `start` is accepted back-to-back (throughput one operation per WIDTH+2 cycles). `div_by_zero` is only meaningful when `done`=1 and is 0 otherwise.
- **Output registering:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=32.
1. **MULTU:** `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `busy` is high for 33 cycles and `done` pulses 33 cycles after acceptance.
2. **MULT:** `a`=−3, `b`=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Also `a`=0x80000000, `b`=0x80000000 → `hi`=0x40000000, `lo`=0.
3. **Divide:**
   - DIV `a`=−7, `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
   - DIVU `a`=100, `b`=7 → `lo`=14, `hi`=2.
   - DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
4. **Divide by zero:** DIVU `a`=5, `b`=0 → after 33 cycles `hi`=5, `lo`=0xFFFFFFFF, with `div_by_zero`=1 in the same cycle as `done`. `div_by_zero`=0 on the next cycle.
5. **Handshake:**
   - `start` pulsed mid-operation is ignored.
   - `flush` on cycle 10 → `busy`=0 next cycle, no `done`, `hi`/`lo` unchanged.
   - MTHI while busy has no effect; MTHI `wdata`=0x1234 while idle → `hi`=0x1234 next cycle.
   - `start` during the `done` cycle is accepted.
6. **Reset:** `rst_n` dropped at cycle 20 of a MULT → all outputs 0 immediately (asynchronous). After release, a new MULTU 6×7 gives `lo`=42, `hi`=0.
